// File: rtl/alu_issue_rv32i_if.sv
// Issue-stage bundle: upstream instr/operand handshake in, ALU operand/control bundle out.
// master drives the stage (fetch/regfile side plus ALU ready); slave is the issue stage.
interface alu_issue_rv32i_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [1:0]      cu_ALUtype;
    logic            cu_adtype;
    logic [1:0]      cu_gatype;
    logic [1:0]      cu_shiftype;
    logic            cu_sltype;
    logic [4:0]      rd;
    logic            illegal;
    logic            illegal_seen;

    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, in1, in2, cu_ALUtype, cu_adtype, cu_gatype,
               cu_shiftype, cu_sltype, rd, illegal, illegal_seen
    );

    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, in1, in2, cu_ALUtype, cu_adtype, cu_gatype,
               cu_shiftype, cu_sltype, rd, illegal, illegal_seen
    );
endinterface

// File: rtl/alu_issue_rv32i.sv
// RV32I ALU decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC, selects operands and holds
// the resulting ALU control bundle in one valid/ready register stage.
module alu_issue_rv32i #(
    parameter int unsigned XLEN = 32
) (
    input logic              clock,
    input logic              rstn,
    alu_issue_rv32i_if.slave bus
);

    localparam logic [6:0] OpcReg   = 7'b0110011;
    localparam logic [6:0] OpcImm   = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    typedef enum logic [1:0] {AluAdd = 2'b00, AluGate = 2'b01, AluShift = 2'b10, AluSlt = 2'b11}
        alu_type_e;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [1:0]      alu_type;
        logic            ad;
        logic [1:0]      ga;
        logic [1:0]      sh;
        logic            sl;
        logic [4:0]      rd;
    } bundle_t;

    bundle_t    dec;
    logic       dec_illegal;
    bundle_t    fn;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;

    bundle_t bundle_q;
    logic    valid_q;
    logic    illegal_q;
    logic    seen_q;
    logic    in_ready;
    logic    capture;

    assign f3 = bus.instr[14:12];
    assign f7 = bus.instr[31:25];

    // funct3 -> ALU control, shared by OP and OP-IMM; instr[30] selects SUB/SRA
    always_comb begin
        fn = '0;
        case (f3)
            3'b000: begin fn.alu_type = AluAdd;   fn.ad = bus.instr[30];        end
            3'b001: begin fn.alu_type = AluShift; fn.sh = 2'b00;                end
            3'b010: begin fn.alu_type = AluSlt;   fn.sl = 1'b0;                 end
            3'b011: begin fn.alu_type = AluSlt;   fn.sl = 1'b1;                 end
            3'b100: begin fn.alu_type = AluGate;  fn.ga = 2'b00;                end
            3'b101: begin fn.alu_type = AluShift;
                          fn.sh = bus.instr[30] ? 2'b10 : 2'b01;                end
            3'b110: begin fn.alu_type = AluGate;  fn.ga = 2'b01;                end
            3'b111: begin fn.alu_type = AluGate;  fn.ga = 2'b10;                end
            default: fn = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        f7_ok       = 1'b0;
        case (bus.instr[6:0])
            OpcReg: begin
                dec     = fn;
                dec.in1 = bus.rs1_data;
                dec.in2 = bus.rs2_data;
                f7_ok   = (f7 == 7'b0000000) ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                dec_illegal = !f7_ok;
            end
            OpcImm: begin
                dec     = fn;
                dec.ad  = 1'b0;
                dec.in1 = bus.rs1_data;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.in2 = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
                    f7_ok   = (f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 == 3'b101);
                    dec_illegal = !f7_ok;
                end else begin
                    dec.in2 = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
                end
            end
            OpcLui: begin
                dec.alu_type = AluAdd;
                dec.in1      = '0;
                dec.in2      = {bus.instr[31:12], 12'b0};
            end
            OpcAuipc: begin
                dec.alu_type = AluAdd;
                dec.in1      = bus.pc;
                dec.in2      = {bus.instr[31:12], 12'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
        dec.rd = bus.instr[11:7];
        // Illegal entries carry an all-zero bundle so the ALU sees a harmless add of zeros
        if (dec_illegal) begin
            dec = '0;
        end
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            seen_q    <= 1'b0;
            bundle_q  <= '0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            illegal_q <= dec_illegal;
            bundle_q  <= dec;
            if (dec_illegal) begin
                seen_q <= 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.in1          = bundle_q.in1;
    assign bus.in2          = bundle_q.in2;
    assign bus.cu_ALUtype   = bundle_q.alu_type;
    assign bus.cu_adtype    = bundle_q.ad;
    assign bus.cu_gatype    = bundle_q.ga;
    assign bus.cu_shiftype  = bundle_q.sh;
    assign bus.cu_sltype    = bundle_q.sl;
    assign bus.rd           = bundle_q.rd;
    assign bus.illegal      = illegal_q;
    assign bus.illegal_seen = seen_q;

endmodule

// File: tb/tb_alu_issue_rv32i.sv
// Directed bench for alu_issue_rv32i: decode vector table plus handshake/flush/reset sequences.
module tb_alu_issue_rv32i;

    logic clock = 1'b0;
    logic rstn  = 1'b0;

    always #5 clock = ~clock;

    alu_issue_rv32i_if #(.XLEN(32)) bus ();

    alu_issue_rv32i #(.XLEN(32)) dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [1:0]  alu;
        logic        ad;
        logic [1:0]  ga;
        logic [1:0]  sh;
        logic        sl;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] in1, input logic [31:0] in2,
                                input logic [1:0] alu, input logic ad, input logic [1:0] ga,
                                input logic [1:0] sh, input logic sl, input logic [4:0] rd,
                                input logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.in1 = in1; v.in2 = in2; v.alu = alu; v.ad = ad; v.ga = ga; v.sh = sh;
        v.sl = sl; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        chk({v.name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, ".in1"}, bus.in1, v.in1);
        chk({v.name, ".in2"}, bus.in2, v.in2);
        chk({v.name, ".ALUtype"}, 32'(bus.cu_ALUtype), 32'(v.alu));
        chk({v.name, ".adtype"}, 32'(bus.cu_adtype), 32'(v.ad));
        chk({v.name, ".gatype"}, 32'(bus.cu_gatype), 32'(v.ga));
        chk({v.name, ".shiftype"}, 32'(bus.cu_shiftype), 32'(v.sh));
        chk({v.name, ".sltype"}, 32'(bus.cu_sltype), 32'(v.sl));
        chk({v.name, ".rd"}, 32'(bus.rd), 32'(v.rd));
        chk({v.name, ".illegal"}, 32'(bus.illegal), 32'(v.ill));
    endtask

    // Presents one instruction at the falling edge; caller advances to the capture edge.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.instr    = instr;
        bus.pc       = pc;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.instr     = 32'h0;
        bus.pc        = 32'h0;
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;

        //        name      instr                               pc       rs1          rs2
        //                  in1          in2          alu ad ga sh sl rd ill
        vecs.push_back(mk("add",  32'h002081B3, 32'h0, 32'd5, 32'd7,
                          32'd5, 32'd7, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd3, 1'b0));
        vecs.push_back(mk("sub",  32'h402081B3, 32'h0, 32'd10, 32'd3,
                          32'd10, 32'd3, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 5'd3, 1'b0));
        vecs.push_back(mk("srai", 32'h40335293, 32'h0, 32'h8000_0000, 32'd9,
                          32'h8000_0000, 32'd3, 2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 5'd5, 1'b0));
        vecs.push_back(mk("lui",  32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF,
                          32'h0, 32'h12345000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd1, 1'b0));
        vecs.push_back(mk("auipc", 32'h00001117, 32'h100, 32'hDEAD, 32'hBEEF,
                          32'h100, 32'h00001000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd2, 1'b0));
        vecs.push_back(mk("xor",  r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd4), 32'h0, 32'hF0F0,
                          32'h0FF0, 32'hF0F0, 32'h0FF0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 5'd4,
                          1'b0));
        vecs.push_back(mk("or",   r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 32'h0, 32'd1,
                          32'd2, 32'd1, 32'd2, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 5'd6, 1'b0));
        vecs.push_back(mk("and",  r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 32'h0, 32'd3,
                          32'd4, 32'd3, 32'd4, 2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 5'd7, 1'b0));
        vecs.push_back(mk("sll",  r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd8), 32'h0, 32'd1,
                          32'd31, 32'd1, 32'd31, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 5'd8, 1'b0));
        vecs.push_back(mk("srl",  r_type(7'h00, 5'd2, 5'd1, 3'b101, 5'd9), 32'h0, 32'd64,
                          32'd2, 32'd64, 32'd2, 2'b10, 1'b0, 2'b00, 2'b01, 1'b0, 5'd9, 1'b0));
        vecs.push_back(mk("sra",  r_type(7'h20, 5'd2, 5'd1, 3'b101, 5'd10), 32'h0, 32'd64,
                          32'd2, 32'd64, 32'd2, 2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 5'd10, 1'b0));
        vecs.push_back(mk("slt",  r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd11), 32'h0, 32'd1,
                          32'd2, 32'd1, 32'd2, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 5'd11, 1'b0));
        vecs.push_back(mk("sltu", r_type(7'h00, 5'd2, 5'd1, 3'b011, 5'd12), 32'h0, 32'd1,
                          32'd2, 32'd1, 32'd2, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 5'd12, 1'b0));
        vecs.push_back(mk("xor_f7", r_type(7'h20, 5'd2, 5'd1, 3'b100, 5'd13), 32'h0, 32'd1,
                          32'd2, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1));
        vecs.push_back(mk("mul",  r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd14), 32'h0, 32'd1,
                          32'd2, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1));
        vecs.push_back(mk("sltiu", i_type(12'h800, 5'd1, 3'b011, 5'd15), 32'h0, 32'd9,
                          32'd0, 32'd9, 32'hFFFF_F800, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 5'd15,
                          1'b0));
        vecs.push_back(mk("xori", i_type(12'h7FF, 5'd1, 3'b100, 5'd16), 32'h0, 32'd9,
                          32'd0, 32'd9, 32'h7FF, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 5'd16, 1'b0));
        vecs.push_back(mk("slli", i_type(12'h01F, 5'd1, 3'b001, 5'd17), 32'h0, 32'd9,
                          32'd0, 32'd9, 32'd31, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 5'd17, 1'b0));
        vecs.push_back(mk("slli_bad", i_type(12'h41F, 5'd1, 3'b001, 5'd18), 32'h0, 32'd9,
                          32'd0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1));
        vecs.push_back(mk("addi_b30", i_type(12'h400, 5'd1, 3'b000, 5'd19), 32'h0, 32'd9,
                          32'd0, 32'd9, 32'h400, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 5'd19, 1'b0));

        // Reset state
        #2;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.illegal_seen", 32'(bus.illegal_seen), 32'd0);
        chk("rst.in1", bus.in1, 32'd0);
        chk("rst.rd", 32'(bus.rd), 32'd0);
        @(negedge clock);
        rstn = 1'b1;

        // Illegal opcode sets the sticky flag; a following legal op clears only illegal
        drive(32'h0000007F, 32'h0, 32'd5, 32'd7);
        step();
        chk("bad.out_valid", 32'(bus.out_valid), 32'd1);
        chk("bad.illegal", 32'(bus.illegal), 32'd1);
        chk("bad.illegal_seen", 32'(bus.illegal_seen), 32'd1);
        chk("bad.in1", bus.in1, 32'd0);
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        step();
        chk("legal.illegal", 32'(bus.illegal), 32'd0);
        chk("legal.illegal_seen", 32'(bus.illegal_seen), 32'd1);

        // Decode table, applied back-to-back with out_ready high
        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            step();
            chk_vec(vecs[i]);
        end

        // Pop with no new capture
        @(negedge clock);
        bus.in_valid = 1'b0;
        step();
        chk("pop.out_valid", 32'(bus.out_valid), 32'd0);
        chk("pop.in_ready", 32'(bus.in_ready), 32'd1);

        // Hold: ADDI stalls for 3 cycles while an ADD waits upstream
        drive(32'hFFF00093, 32'h0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        step();
        chk("hold.cap_in2", bus.in2, 32'hFFFF_FFFF);
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold.in2", bus.in2, 32'hFFFF_FFFF);
            chk("hold.rd", 32'(bus.rd), 32'd1);
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("release.in1", bus.in1, 32'd5);
        chk("release.in2", bus.in2, 32'd7);
        chk("release.rd", 32'(bus.rd), 32'd3);

        // Flush wins over a concurrent capture of an illegal instruction
        drive(32'h0000007F, 32'h0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.illegal", 32'(bus.illegal), 32'd0);

        // Flush of a held illegal entry clears illegal but not illegal_seen
        drive(32'h0000007F, 32'h0, 32'd0, 32'd0);
        bus.flush = 1'b0;
        step();
        chk("flush2.cap_illegal", 32'(bus.illegal), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        chk("flush2.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush2.illegal", 32'(bus.illegal), 32'd0);
        chk("flush2.illegal_seen", 32'(bus.illegal_seen), 32'd1);
        @(negedge clock);
        bus.flush = 1'b0;

        // Asynchronous reset while an entry is held
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        step();
        chk("arst.pre_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst.illegal_seen", 32'(bus.illegal_seen), 32'd0);
        chk("arst.in1", bus.in1, 32'd0);
        chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        rstn = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_rv32i.md
Name: alu_issue_rv32i

Overview:
- Decode/issue stage that produces the operand and control bundle consumed by the RV32I ALU: in1, in2, cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype, cu_sltype.
- Takes a fetched instruction plus register-file read data and PC, decodes ALU-class instructions, and selects operands (rs1/PC/zero, rs2/immediate).
- Holds the result in a single registered stage with valid/ready handshake, flush, and illegal-instruction flagging.

Parameters:
XLEN, 32, datapath width; only 32 supported.

Ports:
clock  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the held entry
in_valid  in  1  instr/pc/rs1_data/rs2_data valid
in_ready  out  1  stage can accept this cycle
instr  in  32  instruction word
pc  in  32  instruction address
rs1_data  in  32  register file read port 1
rs2_data  in  32  register file read port 2
out_valid  out  1  output bundle valid
out_ready  in  1  ALU/execute consumes bundle
in1  out  32  ALU operand 1
in2  out  32  ALU operand 2
cu_ALUtype  out  2  00 adder, 01 gate, 10 shifter, 11 SLT
cu_adtype  out  1  0 add, 1 sub
cu_gatype  out  2  00 XOR, 01 OR, 10 AND, 11 unused
cu_shiftype  out  2  00 SLL, 01 SRL, 10 SRA, 11 unused
cu_sltype  out  1  0 signed, 1 unsigned
rd  out  5  destination register index
illegal  out  1  held instruction not decodable
illegal_seen  out  1  sticky illegal flag

Behaviour:
- Reset (rstn low, async): all outputs 0; out_valid=0, illegal_seen=0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational).
- Capture on rising clock when in_valid && in_ready. Registered decode; latency 1 cycle. Back-to-back throughput of 1/cycle when out_ready is held high.
- Hold: out_valid && !out_ready keeps all outputs stable. Inputs are ignored because in_ready=0.
- Flush has priority over capture: next cycle out_valid=0 and illegal=0, regardless of in_valid. Data outputs are don't-care.
- Pop without new capture: out_valid goes to 0.
- Decode by opcode instr[6:0]:
  - 0110011 OP: in1=rs1, in2=rs2.
    - funct3 000 add: adtype=funct7[5].
    - 001 SLL, 101 SRL/SRA: SRA when funct7[5].
    - 010 SLT signed, 011 SLTU.
    - 100 XOR, 110 OR, 111 AND.
    - funct7 must be 0000000, or 0100000 for SUB/SRA only; otherwise illegal.
  - 0010011 OP-IMM: in2 = sign-extended instr[31:20], same funct3 map, adtype=0.
    - Shifts: in2 = zero-extended shamt instr[24:20].
    - Shift funct7 rule as OP; SRAI uses instr[30].
  - 0110111 LUI: in1=0, in2={instr[31:12],12'b0}, adder add.
  - 0010111 AUIPC: in1=pc, in2=U-immediate, adder add.
  - Any other opcode: illegal.
- Illegal entry: still becomes valid with illegal=1. Outputs in1=0, in2=0, cu_ALUtype=00, adtype=0, rd=0.
- Unused sub-type fields are 0 for non-matching ALU types.
- rd = instr[11:7] for legal entries.
- illegal_seen sets on capture of an illegal entry. It is cleared only by reset; flush does not clear it.
- rstn asserted mid-hold drops out_valid immediately.

Test Plan:
- Reset, then in_valid with instr=0x002081B3 (ADD x3,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, in1=5, in2=7, ALUtype=00, adtype=0, rd=3.
- instr=0x402081B3 (SUB) then 0x40335293 (SRAI x5,x6,3) back-to-back, out_ready=1 -> cycle1 adtype=1; cycle2 ALUtype=10, shiftype=10, in2=3, rd=5, no bubble.
- instr=0x123450B7 (LUI), then 0x00001117 (AUIPC) with pc=0x100 -> in1=0, in2=0x12345000; then in1=0x100, in2=0x00001000.
- instr=0xFFF00093 (ADDI x1,x0,-1) with out_ready=0 for 3 cycles -> in2=0xFFFFFFFF held stable, in_ready=0; accepted next once out_ready=1.
- instr=0x0000007F (bad opcode) -> illegal=1, illegal_seen=1. Next legal ADD gives illegal=0 while illegal_seen stays 1.
- Flush asserted with in_valid=1 and valid entry held -> next cycle out_valid=0. rstn pulse mid-hold -> out_valid=0 asynchronously.
